// File: rtl/pattern_sequencer.sv
// Selects the test pattern for the pixel datapath. The mode only changes on frame
// boundaries; it advances on a debounced button press or automatically every N frames.
module pattern_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 90000,
    parameter int unsigned AUTO_FRAMES     = 300,
    parameter int unsigned NUM_MODES       = 4,
    parameter int unsigned LED_TICKS       = 4500000
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       userbtn,
    input  logic       newframe,
    input  logic       auto_en,
    output logic [1:0] mode,
    output logic       mode_changed,
    output logic [5:0] led
);

    localparam logic [19:0] DB_LAST   = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] AUTO_LAST = 16'(AUTO_FRAMES - 1);
    localparam logic [1:0]  MODE_LAST = 2'(NUM_MODES - 1);
    localparam logic [31:0] LED_LAST  = 32'(LED_TICKS - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic        btn_meta_q;
    logic        btn_sync_q;
    logic [19:0] db_cnt_q;
    logic [19:0] db_cnt_d;
    logic        db_level_q;
    logic        db_level_d;
    logic        press_q;
    logic        press_d;

    logic [15:0] frame_cnt_q;
    logic [15:0] frame_cnt_d;
    logic        auto_fire;
    logic        advance;
    logic [1:0]  mode_next;

    state_t      state_q;
    logic [1:0]  mode_q;
    logic        mode_changed_q;

    logic [31:0] led_cnt_q;
    logic [31:0] led_cnt_d;
    logic [5:0]  led_q;
    logic [5:0]  led_d;

    // Two-flop synchronizer; idles at the released (high) level.
    always_ff @(posedge pclk) begin
        if (reset) begin
            btn_meta_q <= 1'b1;
            btn_sync_q <= 1'b1;
        end else begin
            btn_meta_q <= userbtn;
            btn_sync_q <= btn_meta_q;
        end
    end

    // The new level is accepted only after it has held for DEBOUNCE_CYCLES cycles.
    always_comb begin
        db_cnt_d   = '0;
        db_level_d = db_level_q;
        press_d    = 1'b0;
        if (btn_sync_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = btn_sync_q;
                press_d    = ~btn_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + 20'd1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            db_cnt_q   <= '0;
            db_level_q <= 1'b1;
            press_q    <= 1'b0;
        end else begin
            db_cnt_q   <= db_cnt_d;
            db_level_q <= db_level_d;
            press_q    <= press_d;
        end
    end

    // A pending press and an auto tick landing on the same frame merge into one step.
    assign auto_fire = newframe && auto_en && (frame_cnt_q == AUTO_LAST);
    assign advance   = newframe && ((state_q == PENDING) || auto_fire);
    assign mode_next = (mode_q == MODE_LAST) ? 2'd0 : mode_q + 2'd1;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (!auto_en || advance) begin
            frame_cnt_d = '0;
        end else if (newframe) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q        <= IDLE;
            mode_q         <= 2'd0;
            mode_changed_q <= 1'b0;
        end else begin
            mode_changed_q <= advance;
            if (advance) begin
                mode_q <= mode_next;
            end
            case (state_q)
                IDLE: begin
                    if (press_q) begin
                        state_q <= PENDING;
                    end
                end
                PENDING: begin
                    if (newframe) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Heartbeat chaser, free-running and independent of the mode logic.
    always_comb begin
        led_cnt_d = led_cnt_q + 32'd1;
        led_d     = led_q;
        if (led_cnt_q == LED_LAST) begin
            led_cnt_d = '0;
            led_d     = {led_q[4:0], led_q[5]};
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            led_cnt_q <= '0;
            led_q     <= 6'b111110;
        end else begin
            led_cnt_q <= led_cnt_d;
            led_q     <= led_d;
        end
    end

    assign mode         = mode_q;
    assign mode_changed = mode_changed_q;
    assign led          = led_q;

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
- Control block that selects which test pattern the pixel datapath draws.
- Takes the raw user button and the frame-start strobe from the video timing generator, and produces a 2-bit pattern mode.
- Mode changes happen only on frame boundaries, so no frame is ever torn.
- Optionally auto-cycles patterns every N frames, and drives the board LED chaser as a heartbeat.

Parameters:
- DEBOUNCE_CYCLES, 90000, pclk cycles userbtn must hold a new level before it is accepted (~10 ms at 9 MHz); legal range 2..2^20-1.
- AUTO_FRAMES, 300, frames between automatic mode advances when auto_en=1; legal range 1..65535.
- NUM_MODES, 4, number of valid modes; legal range 1..4; mode wraps from NUM_MODES-1 to 0.
- LED_TICKS, 4500000, pclk cycles per LED rotation step; legal range 1..2^32-1.

Ports:
- pclk  in  1  pixel clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- userbtn  in  1  raw push button, active-low, asynchronous to pclk.
- newframe  in  1  one-pclk pulse from the timing generator at the start of each frame.
- auto_en  in  1  level; 1 enables automatic cycling.
- mode  out  2  current pattern select for the pixel datapath.
- mode_changed  out  1  one-cycle pulse in the cycle after mode takes a new value.
- led  out  6  active-low one-cold LED chaser.

Behaviour:
- Reset (reset=1 at a pclk edge):
  - mode=0, mode_changed=0, led=6'b111110.
  - FSM goes to IDLE; debounce counter, frame counter and LED counter go to 0.
  - Synchronizer flops and the debounced level go to 1 (released).
  - Reset has priority over every other event, including mid-debounce or in PENDING; a pending advance is discarded.
- Input sync: userbtn passes through two flops before any use, so 2 cycles of latency.
- Debounce:
  - When the synced input differs from the debounced level, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the input still different, the debounced level takes the input value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced level.
- Press event: a one-cycle internal pulse when the debounced level goes 1->0. Release (0->1) generates no event.
- Mode FSM, two states:
  - IDLE: a press moves to PENDING. A press in the same cycle as newframe still goes to PENDING; it is applied at the next newframe, not the current one.
  - PENDING: on newframe, advance and return to IDLE. Presses while in PENDING are ignored; there is no queue and at most one advance per frame.
- Advance:
  - mode <= (mode==NUM_MODES-1) ? 0 : mode+1.
  - mode_changed=1 for exactly the next cycle.
  - The frame counter clears.
  - With NUM_MODES=1, mode stays 0 but mode_changed still pulses.
- Auto cycling:
  - While auto_en=1, each newframe increments a 16-bit frame counter.
  - A newframe that arrives with the counter at AUTO_FRAMES-1 causes an advance.
  - If that same newframe also completes a PENDING press, only one advance occurs and the FSM returns to IDLE.
  - auto_en=0 holds the frame counter at 0.
- mode timing: mode changes only on the pclk edge that samples newframe=1, and holds otherwise, so the datapath sees a stable mode for the whole frame.
- LED chaser:
  - The counter increments each cycle.
  - At LED_TICKS-1 it clears and led rotates left: led <= {led[4:0], led[5]}.
  - The chaser runs independently of mode; exactly one bit is 0 at all times.
- Widths: debounce counter 20 bits, frame counter 16 bits, LED counter 32 bits. Comparisons are unsigned and no counter ever wraps without clearing.

Test Plan (bench parameters DEBOUNCE_CYCLES=8, AUTO_FRAMES=3, NUM_MODES=4, LED_TICKS=5; newframe every 100 cycles):
- Reset for 2 cycles -> mode=0, mode_changed=0, led=111110; after 5 more cycles led=111101, after 10 led=111011.
- userbtn low for 5 cycles, then high -> no press event; mode stays 0 across 3 frames.
- userbtn low for 20 cycles, starting mid-frame -> mode stays 0 until the next newframe edge, then mode=1. mode_changed is high for exactly 1 cycle, the one after that edge.
- Two valid presses within one frame -> exactly one advance (0->1) at the next newframe; a third press in the following frame -> mode=2 at the frame after.
- auto_en=1 with no presses -> mode goes 0->1->2->3->0 at every 3rd newframe. A press pending on an auto-advance frame -> single step only; the counter restarts from 0.
- Press, then reset asserted while in PENDING, then newframe -> mode=0, no mode_changed pulse; a subsequent press advances normally to 1.
